// File: rtl/voice_phase_acc.sv
// Time-multiplexed per-voice phase accumulator bank fed by an external note-to-increment mapper.
// Optional VOICE_PHASE_ACC_RETRIG_EN: a key-on write also zeroes that voice's phase.
module voice_phase_acc #(
  parameter int VOICES      = 32,
  parameter int V_WIDTH     = 5,
  parameter int PHASE_WIDTH = 32,
  parameter int CONST_WIDTH = 24
) (
  input  logic                   sCLK_XVXENVS,
  input  logic                   reset_reg_N,
  input  logic                   sample_tick,
  input  logic                   key_wr,
  input  logic [V_WIDTH-1:0]     key_voice,
  input  logic [8:0]             key_sound,
  input  logic                   key_on,
  output logic [8:0]             sound_out,
  input  logic [CONST_WIDTH-1:0] constant_in,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [V_WIDTH-1:0]     phase_voice,
  output logic                   phase_valid,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state, state_next;
  logic [V_WIDTH-1:0]     vcnt;
  logic [V_WIDTH-1:0]     vcnt_inc;
  logic                   last;
  logic [8:0]             note  [VOICES];
  logic [VOICES-1:0]      gate;
  logic [PHASE_WIDTH-1:0] phase [VOICES];
  logic [PHASE_WIDTH-1:0] inc;
  logic [PHASE_WIDTH-1:0] sum;
  logic                   retrig_hit;

  assign last     = (vcnt == V_WIDTH'(VOICES - 1));
  assign vcnt_inc = vcnt + V_WIDTH'(1);
  assign busy     = (state == SWEEP);

  // Gate only selects the increment; a silent voice still reports its held phase.
  assign inc = gate[vcnt] ? PHASE_WIDTH'(constant_in) : '0;
  assign sum = phase[vcnt] + inc;

`ifdef VOICE_PHASE_ACC_RETRIG_EN
  assign retrig_hit = key_wr && key_on && (key_voice == vcnt);
`else
  assign retrig_hit = 1'b0;
`endif

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick)          state_next = SWEEP;
      SWEEP:   if (last && !sample_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_next;
  end

  // NOTE: the note/gate/phase arrays are reset explicitly because the spec requires all voices to read 0 after reset.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < VOICES; i++) begin
        note[i]  <= '0;
        phase[i] <= '0;
      end
      gate        <= '0;
      vcnt        <= '0;
      sound_out   <= '0;
      phase_out   <= '0;
      phase_voice <= '0;
      phase_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      phase_valid <= 1'b0;
      overrun     <= 1'b0;
      if (state == IDLE) begin
        if (sample_tick) begin
          vcnt      <= '0;
          sound_out <= note[0];
        end
      end else begin
        phase[vcnt] <= sum;
        phase_out   <= retrig_hit ? '0 : sum;
        phase_voice <= vcnt;
        phase_valid <= 1'b1;
        if (last) begin
          // A tick landing on the final edge rolls straight into the next sweep.
          vcnt      <= '0;
          sound_out <= note[0];
        end else begin
          vcnt      <= vcnt_inc;
          sound_out <= note[vcnt_inc];
          overrun   <= sample_tick;
        end
      end
      if (key_wr) begin
        note[key_voice] <= key_sound;
        gate[key_voice] <= key_on;
`ifdef VOICE_PHASE_ACC_RETRIG_EN
        // Placed after the accumulate so the clear overrides a same-edge update.
        if (key_on) phase[key_voice] <= '0;
`endif
      end
    end
  end

endmodule
